uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Controller that sits behind the UART receiver, clocked by the same bclk_x8. It watches the receiver's rx_status/flag, captures each completed 10-bit frame, checks framing, and pushes the data byte into a small show-ahead FIFO with a valid/ready consumer handshake. It also supervises the receiver: a stuck frame triggers a watchdog that pulses a receiver reset, and frame/overrun/timeout errors are reported as sticky flags.

Parameters:
FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.
TIMEOUT_CYCLES, 128, max bclk_x8 cycles in RECV before the watchdog fires; range 16..1023.

Ports:
bclk_x8  in  1  clock.
rst  in  1  reset.
rx_status  in  1  receiver busy, high while a frame is sampled.
rx_output  in  10  receiver frame: [0] start bit, [8:1] data LSB first, [9] stop bit.
flag  in  1  receiver frame-done indication.
rx_rst  out  1  one-cycle reset pulse to the receiver on timeout.
data_out  out  8  FIFO head byte.
data_valid  out  1  FIFO non-empty.
data_ready  in  1  consumer accepts data_out.
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
framing_err  out  1  sticky: bad start or stop bit.
overrun_err  out  1  sticky: frame dropped because the FIFO was full.
timeout_err  out  1  sticky: watchdog fired.
err_clear  in  1  clears all sticky errors.

Behaviour:
- Single clock, bclk_x8. Reset rst is synchronous and active-high.
- Reset values: FSM to IDLE, pointers/fifo_count/timer 0, all errors 0, rx_rst 0, data_valid 0, data_out 0 (FIFO memory not cleared; data_out shows the entry at rd_ptr).
- Reset mid-frame or mid-FIFO discards everything. No stale push after reset deassertion.
- flag_rise = flag & ~flag_q, where flag_q is registered. Only the rising edge counts, so a multi-cycle flag gives one capture.
- FSM states:
  - IDLE: rx_status=1 -> RECV (timer cleared).
  - RECV: timer increments each cycle. flag_rise -> CHECK. Timer == TIMEOUT_CYCLES-1 with no flag_rise -> RECOVER. If flag_rise and timeout occur together, flag_rise wins.
  - CHECK: one cycle; evaluates the latched frame, then -> IDLE.
  - RECOVER: rx_rst=1 for exactly this cycle, timeout_err set, then -> IDLE.
- flag_rise in IDLE also goes to CHECK, since the receiver may drop rx_status before flag.
- On flag_rise, rx_output is latched into frame_q at that edge.
- CHECK evaluation of frame_q:
  - frame_q[0]==0 and frame_q[9]==1: frame OK. Push frame_q[8:1] if not full; if full, drop the frame and set overrun_err.
  - Otherwise: drop the frame and set framing_err.
- Latency: flag_rise sampled at edge N; FIFO write at edge N+1; data_valid=1 after edge N+1 when the FIFO was empty.
- FIFO:
  - Show-ahead: data_out = mem[rd_ptr], data_valid = (count!=0).
  - Pop on data_valid & data_ready; data_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: count unchanged. When full, the pop frees the slot, so the push is accepted with no overrun.
- Sticky errors: set event and err_clear in the same cycle leaves the bit set.
- rx_rst is never asserted outside RECOVER.

Optional Feature:
ERR_COUNT_EN: when defined, adds output err_count[7:0]. It is a saturating count (stops at 255) of framing+overrun+timeout events, cleared by rst or err_clear; a same-cycle event with err_clear gives 1. When undefined, the port and its logic are absent.

Test Plan:
- Good frame rx_output=10'b1_10100101_0, with flag pulsed 1 cycle after rx_status high -> data_out=8'hA5, data_valid high 2 edges after the flag rise edge; pop with data_ready=1 -> fifo_count 1->0.
- Frame with stop bit 0 (rx_output=10'b0_00001111_0) -> framing_err=1, fifo_count unchanged; err_clear=1 for one cycle -> framing_err=0.
- Push 5 good frames 8'h01..8'h05 with data_ready=0, FIFO_DEPTH=4 -> fifo_count=4, overrun_err=1, pops yield 01,02,03,04.
- rx_status held high for 128 cycles, no flag -> rx_rst high exactly 1 cycle, timeout_err=1, FSM back to IDLE; next good frame is accepted normally.
- FIFO full plus new good frame in the same CHECK cycle as data_ready=1 -> no overrun, fifo_count stays 4, new byte appears last.
- rst asserted 1 cycle between flag rise and CHECK -> fifo_count=0, no errors, data_valid=0, no push afterwards.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: captures frames on the rising edge of
// flag, checks start/stop bits and queues data bytes in a show-ahead FIFO.
// A watchdog pulses rx_rst when a frame stalls; errors are sticky.
// Ports:
//   bclk_x8, rst          clock, sync active-high reset
//   rx_status, rx_output  receiver busy and 10-bit frame {stop,data,start}
//   flag                  receiver frame-done indication
//   rx_rst                one-cycle receiver reset on watchdog timeout
//   data_out, data_valid  FIFO head byte and non-empty
//   data_ready            consumer accept
//   fifo_count            entries held
//   framing_err, overrun_err, timeout_err  sticky errors
//   err_clear             clears all sticky errors
//   err_count             saturating error-event count (ERR_COUNT_EN only)
// Optional feature macro: ERR_COUNT_EN
module uart_rx_frame_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                          bclk_x8,
    input  logic                          rst,
    input  logic                          rx_status,
    input  logic [9:0]                    rx_output,
    input  logic                          flag,
    output logic                          rx_rst,
    output logic [7:0]                    data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          overrun_err,
    output logic                          timeout_err,
    input  logic                          err_clear
`ifdef ERR_COUNT_EN
    ,
    output logic [7:0]                    err_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 10;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK,
        RECOVER
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            flag_q;
    logic            flag_rise;
    logic [TW-1:0]   timer;
    logic            timeout_hit;
    logic [9:0]      frame_q;
    logic            frame_ok;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            push;
    logic            pop;
    logic            ev_frame;
    logic            ev_ovr;
    logic            ev_tmo;

    assign flag_rise   = flag & ~flag_q;
    assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));
    assign frame_ok    = ~frame_q[0] & frame_q[9];
    assign full        = (count == CW'(FIFO_DEPTH));
    assign data_valid  = (count != '0);
    assign pop         = data_valid & data_ready;
    assign data_out    = mem[rd_ptr];
    assign fifo_count  = count;

    always_ff @(posedge bclk_x8) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rx_rst   = 1'b0;
        push     = 1'b0;
        ev_frame = 1'b0;
        ev_ovr   = 1'b0;
        ev_tmo   = 1'b0;
        unique case (state)
            // Receiver may drop rx_status before flag, so flag wins here too.
            IDLE: begin
                if (flag_rise)      state_n = CHECK;
                else if (rx_status) state_n = RECV;
            end
            RECV: begin
                if (flag_rise)        state_n = CHECK;
                else if (timeout_hit) state_n = RECOVER;
            end
            CHECK: begin
                state_n = IDLE;
                if (frame_ok) begin
                    // A same-cycle pop frees the slot for this push.
                    if (!full || pop) push   = 1'b1;
                    else              ev_ovr = 1'b1;
                end else begin
                    ev_frame = 1'b1;
                end
            end
            RECOVER: begin
                rx_rst  = 1'b1;
                ev_tmo  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge bclk_x8) begin
        // Tracking flag during reset keeps a held flag from looking new.
        flag_q <= flag;
        if (rst) begin
            timer       <= '0;
            frame_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timer <= (state == RECV) ? timer + 1'b1 : '0;
            if (flag_rise && (state == IDLE || state == RECV))
                frame_q <= rx_output;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            framing_err <= ev_frame | (framing_err & ~err_clear);
            overrun_err <= ev_ovr   | (overrun_err & ~err_clear);
            timeout_err <= ev_tmo   | (timeout_err & ~err_clear);
        end
    end

    always_ff @(posedge bclk_x8) begin
        if (push && !rst) mem[wr_ptr] <= frame_q[8:1];
    end

`ifdef ERR_COUNT_EN
    logic any_ev;
    assign any_ev = ev_frame | ev_ovr | ev_tmo;

    always_ff @(posedge bclk_x8) begin
        if (rst)
            err_count <= '0;
        else if (err_clear)
            err_count <= {7'd0, any_ev};
        else if (any_ev && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: frame table plus hand
// sequences for latency, overrun, watchdog, full+pop and mid-frame reset.
module tb_uart_rx_frame_ctrl;

    localparam int D = 4;

    logic       bclk_x8 = 1'b0;
    logic       rst;
    logic       rx_status;
    logic [9:0] rx_output;
    logic       flag;
    logic       rx_rst;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [2:0] fifo_count;
    logic       framing_err;
    logic       overrun_err;
    logic       timeout_err;
    logic       err_clear;
`ifdef ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    uart_rx_frame_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(128)) dut (
        .bclk_x8     (bclk_x8),
        .rst         (rst),
        .rx_status   (rx_status),
        .rx_output   (rx_output),
        .flag        (flag),
        .rx_rst      (rx_rst),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .fifo_count  (fifo_count),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .timeout_err (timeout_err),
        .err_clear   (err_clear)
`ifdef ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 bclk_x8 = ~bclk_x8;

    typedef struct {
        logic [9:0] frame;
        logic       exp_fe;
        logic [2:0] exp_cnt;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_fe;
    logic       exp_ovr;
    logic       exp_to;
    vec_t       vt[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Drives one frame; optional pop and err_clear during the CHECK cycle.
    // Returns at the negedge after the FIFO write edge.
    task automatic send(input logic [9:0] f, input bit pop_chk,
                        input bit clr_chk);
        @(negedge bclk_x8);
        rx_status = 1'b1;
        rx_output = f;
        @(negedge bclk_x8);
        flag = 1'b1;
        @(negedge bclk_x8);
        flag      = 1'b0;
        rx_status = 1'b0;
        if (pop_chk) begin
            chk("check_valid", 32'(data_valid), 1);
            if (exp_q.size() > 0)
                chk("check_head", 32'(data_out), 32'(exp_q.pop_front()));
            data_ready = 1'b1;
        end
        if (clr_chk) begin
            err_clear = 1'b1;
            exp_fe    = 1'b0;
            exp_ovr   = 1'b0;
            exp_to    = 1'b0;
        end
        if (f[0] == 1'b0 && f[9] == 1'b1) begin
            if (exp_q.size() < D) exp_q.push_back(f[8:1]);
            else                  exp_ovr = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
        @(negedge bclk_x8);
        data_ready = 1'b0;
        err_clear  = 1'b0;
    endtask

    task automatic pop_one();
        chk("pop_valid", 32'(data_valid), 1);
        if (exp_q.size() > 0)
            chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
        else
            chk("pop_model_empty", 0, 1);
        data_ready = 1'b1;
        @(negedge bclk_x8);
        data_ready = 1'b0;
    endtask

    task automatic check_state(input string name);
        chk({name, "_count"}, 32'(fifo_count), exp_q.size());
        chk({name, "_fe"}, 32'(framing_err), 32'(exp_fe));
        chk({name, "_ovr"}, 32'(overrun_err), 32'(exp_ovr));
        chk({name, "_to"}, 32'(timeout_err), 32'(exp_to));
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        @(negedge bclk_x8);
        err_clear = 1'b0;
        exp_fe    = 1'b0;
        exp_ovr   = 1'b0;
        exp_to    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int at;
        int highs;

        vt[0] = '{10'b1_10100101_0, 1'b0, 3'd1};
        vt[1] = '{10'b0_00001111_0, 1'b1, 3'd1};
        vt[2] = '{10'b1_00110011_1, 1'b1, 3'd1};
        vt[3] = '{10'b1_00111100_0, 1'b1, 3'd2};

        rst        = 1'b1;
        rx_status  = 1'b0;
        rx_output  = '0;
        flag       = 1'b0;
        data_ready = 1'b0;
        err_clear  = 1'b0;
        exp_fe     = 1'b0;
        exp_ovr    = 1'b0;
        exp_to     = 1'b0;
        repeat (3) @(negedge bclk_x8);
        rst = 1'b0;
        check_state("reset");
        chk("reset_valid", 32'(data_valid), 0);
        chk("reset_rx_rst", 32'(rx_rst), 0);

        // Latency: valid appears after the write edge, not the rise edge.
        @(negedge bclk_x8);
        rx_status = 1'b1;
        rx_output = mk(8'hA5);
        @(negedge bclk_x8);
        flag = 1'b1;
        @(negedge bclk_x8);
        flag      = 1'b0;
        rx_status = 1'b0;
        chk("lat_valid_n", 32'(data_valid), 0);
        exp_q.push_back(8'hA5);
        @(negedge bclk_x8);
        chk("lat_valid_n1", 32'(data_valid), 1);
        chk("lat_data", 32'(data_out), 32'h A5);
        chk("lat_count", 32'(fifo_count), 1);
        pop_one();
        chk("lat_count_after_pop", 32'(fifo_count), 0);
        chk("lat_valid_after_pop", 32'(data_valid), 0);

        // Ready while empty does nothing.
        data_ready = 1'b1;
        repeat (2) @(negedge bclk_x8);
        data_ready = 1'b0;
        chk("empty_pop_count", 32'(fifo_count), 0);

        for (int i = 0; i < 4; i++) begin
            send(vt[i].frame, 1'b0, 1'b0);
            chk($sformatf("vec%0d_count", i), 32'(fifo_count),
                32'(vt[i].exp_cnt));
            chk($sformatf("vec%0d_fe", i), 32'(framing_err),
                32'(vt[i].exp_fe));
        end
        while (exp_q.size() > 0) pop_one();
        clear_errs();
        check_state("err_clear");

        // Multi-cycle flag yields a single capture.
        @(negedge bclk_x8);
        rx_status = 1'b1;
        rx_output = mk(8'h77);
        @(negedge bclk_x8);
        flag = 1'b1;
        repeat (4) @(negedge bclk_x8);
        flag      = 1'b0;
        rx_status = 1'b0;
        exp_q.push_back(8'h77);
        repeat (2) @(negedge bclk_x8);
        check_state("long_flag");
        pop_one();

        // Overrun: five frames into a four-entry FIFO.
        for (int b = 1; b <= 5; b++) send(mk(8'(b)), 1'b0, 1'b0);
        check_state("overrun");
        chk("overrun_set", 32'(overrun_err), 1);
        while (exp_q.size() > 0) pop_one();
        clear_errs();

        // Watchdog: RECV entered one edge after rx_status, then 128 cycles.
        @(negedge bclk_x8);
        rx_status = 1'b1;
        at        = 0;
        highs     = 0;
        for (int i = 1; i <= 300 && at == 0; i++) begin
            @(negedge bclk_x8);
            if (rx_rst) begin
                at        = i;
                highs++;
                rx_status = 1'b0;
            end
        end
        rx_status = 1'b0;
        chk("wdog_cycle", at, 129);
        for (int i = 0; i < 20; i++) begin
            @(negedge bclk_x8);
            if (rx_rst) highs++;
        end
        chk("wdog_width", highs, 1);
        exp_to = 1'b1;
        check_state("wdog");
        send(mk(8'h5A), 1'b0, 1'b0);
        check_state("after_wdog");
        pop_one();
        clear_errs();
        check_state("wdog_clear");

        // Full FIFO with a pop in the CHECK cycle: no overrun.
        send(mk(8'h11), 1'b0, 1'b0);
        send(mk(8'h22), 1'b0, 1'b0);
        send(mk(8'h33), 1'b0, 1'b0);
        send(mk(8'h44), 1'b0, 1'b0);
        chk("full_count", 32'(fifo_count), 4);
        send(mk(8'h55), 1'b1, 1'b0);
        check_state("full_pop");
        while (exp_q.size() > 0) pop_one();

        // Framing error with err_clear in the same cycle stays set.
        send(10'b0_11110000_0, 1'b0, 1'b1);
        check_state("sticky_same");
        chk("sticky_fe", 32'(framing_err), 1);

        // Reset between flag rise and CHECK drops everything.
        send(mk(8'h99), 1'b0, 1'b0);
        @(negedge bclk_x8);
        rx_status = 1'b1;
        rx_output = mk(8'hC3);
        @(negedge bclk_x8);
        flag = 1'b1;
        @(negedge bclk_x8);
        flag      = 1'b0;
        rx_status = 1'b0;
        rst       = 1'b1;
        @(negedge bclk_x8);
        rst = 1'b0;
        exp_q.delete();
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
        check_state("mid_rst");
        chk("mid_rst_valid", 32'(data_valid), 0);
        repeat (5) @(negedge bclk_x8);
        check_state("post_rst");
        chk("post_rst_valid", 32'(data_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
